// File: rtl/dh_keyx_engine_pkg.sv
// Shared types and constants for the Diffie-Hellman key-exchange engine (package dh_pkg).
// Optional key-match output is enabled by defining DH_KEY_MATCH_EN.
package dh_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_PA = 3'd1,
        RUN_PB = 3'd2,
        RUN_KA = 3'd3,
        RUN_KB = 3'd4,
        FIN    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_LOAD = 2'd1,
        C_ITER = 2'd2,
        C_DONE = 2'd3
    } core_state_t;

    localparam int DEF_W     = 8;
    localparam int DEF_EXP_W = 8;
    localparam int LAT       = 4 * DEF_EXP_W + 9;

    // Start-to-done latency for a given exponent width.
    function automatic int lat_f(input int exp_w);
        return 4 * exp_w + 9;
    endfunction

endpackage

// File: rtl/dh_keyx_engine_if.sv
// Request/result bundle between the front end (master) and the key-exchange engine (slave).
// Handshake: start_i is a one-cycle request honoured only when the engine is idle; done_o pulses once when results are valid.
interface dh_keyx_if #(
    parameter int W     = 8,
    parameter int EXP_W = 8
) ();
    import dh_pkg::*;

    logic             start_i;
    logic [W-1:0]     g_i;
    logic [W-1:0]     p_i;
    logic [EXP_W-1:0] a_i;
    logic [EXP_W-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [W-1:0]     pub_a_o;
    logic [W-1:0]     pub_b_o;
    logic [W-1:0]     key_a_o;
    logic [W-1:0]     key_b_o;
    state_t           dbg_state;
`ifdef DH_KEY_MATCH_EN
    logic             key_ok_o;
`endif

    modport master (
        output start_i, g_i, p_i, a_i, b_i,
`ifdef DH_KEY_MATCH_EN
        input  key_ok_o,
`endif
        input  busy_o, done_o, err_o, pub_a_o, pub_b_o, key_a_o, key_b_o, dbg_state
    );

    modport slave (
        input  start_i, g_i, p_i, a_i, b_i,
`ifdef DH_KEY_MATCH_EN
        output key_ok_o,
`endif
        output busy_o, done_o, err_o, pub_a_o, pub_b_o, key_a_o, key_b_o, dbg_state
    );

endinterface

// File: rtl/dh_keyx_engine_modexp_core.sv
// Constant-time square-and-multiply core: result = base^exp mod mod, always EXP_W iterations.
// Loads on the start cycle, iterates EXP_W cycles, pulses done_o the cycle after.
module dh_modexp_core
    import dh_pkg::*;
#(
    parameter int W     = 8,
    parameter int EXP_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start_i,
    input  logic [W-1:0]     base_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [W-1:0]     mod_i,
    output logic             done_o,
    output logic [W-1:0]     result_o
);

    localparam int CW = $clog2(EXP_W + 1);

    core_state_t      r_state;
    logic [W-1:0]     r_r;
    logic [W-1:0]     r_x;
    logic [EXP_W-1:0] r_e;
    logic [W-1:0]     r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    core_state_t      w_phase;
    logic [2*W-1:0]   w_rx;
    logic [2*W-1:0]   w_xx;
    logic [2*W-1:0]   w_rx_red;
    logic [2*W-1:0]   w_xx_red;
    logic [W-1:0]     w_base_red;
    logic [W-1:0]     w_one;

    // The load cycle is the start cycle itself; registers take the operands on its closing edge.
    assign w_phase = (r_state == C_IDLE && start_i) ? C_LOAD : r_state;

    // Full 2W-bit products, reduced without any intermediate truncation.
    assign w_rx     = {{W{1'b0}}, r_r} * {{W{1'b0}}, r_x};
    assign w_xx     = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_x};
    assign w_rx_red = (r_m == '0) ? '0 : (w_rx % {{W{1'b0}}, r_m});
    assign w_xx_red = (r_m == '0) ? '0 : (w_xx % {{W{1'b0}}, r_m});

    assign w_base_red = (mod_i == '0) ? '0 : (base_i % mod_i);
    assign w_one      = {{(W-1){1'b0}}, (mod_i > 1)};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= C_IDLE;
            r_r     <= '0;
            r_x     <= '0;
            r_e     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (w_phase)
                C_LOAD: begin
                    r_r     <= w_one;
                    r_x     <= w_base_red;
                    r_e     <= exp_i;
                    r_m     <= mod_i;
                    r_cnt   <= '0;
                    r_state <= C_ITER;
                end
                C_ITER: begin
                    if (r_e[0]) begin
                        r_r <= w_rx_red[W-1:0];
                    end
                    r_x   <= w_xx_red[W-1:0];
                    r_e   <= r_e >> 1;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(EXP_W - 1)) begin
                        r_state <= C_DONE;
                        r_done  <= 1'b1;
                    end
                end
                C_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= C_IDLE;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done_o   = r_done;
    assign result_o = r_r;

endmodule

// File: rtl/dh_keyx_engine.sv
// Diffie-Hellman key-exchange engine: A=g^a, B=g^b, K_A=B^a, K_B=A^b mod p on one shared core.
// Define DH_KEY_MATCH_EN to add key_ok_o (K_A == K_B on a valid run).
module dh_keyx_engine
    import dh_pkg::*;
#(
    parameter int W     = 8,
    parameter int EXP_W = 8
) (
    input logic     CLK,
    input logic     RST_N,
    dh_keyx_if.slave bus
);

    state_t           r_state;
    logic [W-1:0]     r_g;
    logic [W-1:0]     r_p;
    logic [EXP_W-1:0] r_a;
    logic [EXP_W-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [W-1:0]     r_pub_a;
    logic [W-1:0]     r_pub_b;
    logic [W-1:0]     r_key_a;
    logic [W-1:0]     r_key_b;
    logic             r_core_start;
`ifdef DH_KEY_MATCH_EN
    logic             r_key_ok;
`endif

    logic [W-1:0]     w_core_base;
    logic [EXP_W-1:0] w_core_exp;
    logic             w_core_done;
    logic [W-1:0]     w_core_res;

    // Operand selection follows the run state; the core samples it on its start cycle.
    always_comb begin
        w_core_base = r_g;
        w_core_exp  = r_a;
        case (r_state)
            RUN_PB: begin w_core_base = r_g;     w_core_exp = r_b; end
            RUN_KA: begin w_core_base = r_pub_b; w_core_exp = r_a; end
            RUN_KB: begin w_core_base = r_pub_a; w_core_exp = r_b; end
            default: begin w_core_base = r_g;    w_core_exp = r_a; end
        endcase
    end

    dh_modexp_core #(.W(W), .EXP_W(EXP_W)) u_core (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start_i  (r_core_start),
        .base_i   (w_core_base),
        .exp_i    (w_core_exp),
        .mod_i    (r_p),
        .done_o   (w_core_done),
        .result_o (w_core_res)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_g          <= '0;
            r_p          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pub_a      <= '0;
            r_pub_b      <= '0;
            r_key_a      <= '0;
            r_key_b      <= '0;
            r_core_start <= 1'b0;
`ifdef DH_KEY_MATCH_EN
            r_key_ok     <= 1'b0;
`endif
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_g     <= bus.g_i;
                        r_p     <= bus.p_i;
                        r_a     <= bus.a_i;
                        r_b     <= bus.b_i;
                        r_pub_a <= '0;
                        r_pub_b <= '0;
                        r_key_a <= '0;
                        r_key_b <= '0;
                        r_err   <= (bus.p_i == '0);
`ifdef DH_KEY_MATCH_EN
                        r_key_ok <= 1'b0;
`endif
                        // A zero modulus has no valid result: report straight away.
                        if (bus.p_i == '0) begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= RUN_PA;
                            r_busy       <= 1'b1;
                            r_core_start <= 1'b1;
                        end
                    end
                end
                RUN_PA: if (w_core_done) begin
                    r_pub_a      <= w_core_res;
                    r_state      <= RUN_PB;
                    r_core_start <= 1'b1;
                end
                RUN_PB: if (w_core_done) begin
                    r_pub_b      <= w_core_res;
                    r_state      <= RUN_KA;
                    r_core_start <= 1'b1;
                end
                RUN_KA: if (w_core_done) begin
                    r_key_a      <= w_core_res;
                    r_state      <= RUN_KB;
                    r_core_start <= 1'b1;
                end
                RUN_KB: if (w_core_done) begin
                    r_key_b <= w_core_res;
                    r_state <= FIN;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
`ifdef DH_KEY_MATCH_EN
                    r_key_ok <= (r_key_a == r_key_b) && !r_err;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.err_o     = r_err;
    assign bus.pub_a_o   = r_pub_a;
    assign bus.pub_b_o   = r_pub_b;
    assign bus.key_a_o   = r_key_a;
    assign bus.key_b_o   = r_key_b;
    assign bus.dbg_state = r_state;
`ifdef DH_KEY_MATCH_EN
    assign bus.key_ok_o  = r_key_ok;
`endif

endmodule

// File: tb/tb_dh_keyx_engine.sv
// Self-checking bench for dh_keyx_engine: directed plan steps plus random runs against a repeated-multiplication model.
module tb_dh_keyx_engine;
    import dh_pkg::*;

    localparam int W     = 8;
    localparam int EXP_W = 8;
    localparam int NLAT  = 4 * EXP_W + 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    dh_keyx_if #(.W(W), .EXP_W(EXP_W)) bus ();

    dh_keyx_engine #(.W(W), .EXP_W(EXP_W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // base^e mod p by plain repeated multiplication.
    function automatic int ref_pow(input int base, input int e, input int p);
        int r;
        if (p == 0) return 0;
        r = 1 % p;
        for (int i = 0; i < e; i++) r = (r * base) % p;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_o), 0);
        check({tag, "_done"}, 32'(bus.done_o), 0);
        check({tag, "_err"},  32'(bus.err_o), 0);
        check({tag, "_res"},  {bus.pub_a_o, bus.pub_b_o, bus.key_a_o, bus.key_b_o}, 0);
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(IDLE));
    endtask

    task automatic run_check(input string tag, input int g, input int p, input int a, input int b,
                             input bit poke_start);
        int lat, k, done_at, busy_bad, ea, eb, eka, ekb;
        logic [W-1:0] xa, xb, xka, xkb;
        if (p == 0) begin
            lat = 1;
            ea = 0; eb = 0; eka = 0; ekb = 0;
        end else begin
            lat = NLAT;
            ea  = ref_pow(g, a, p);
            eb  = ref_pow(g, b, p);
            eka = ref_pow(eb, a, p);
            ekb = ref_pow(ea, b, p);
        end
        exp_q.push_back(W'(ea));
        exp_q.push_back(W'(eb));
        exp_q.push_back(W'(eka));
        exp_q.push_back(W'(ekb));

        @(negedge clk);
        bus.g_i = W'(g); bus.p_i = W'(p); bus.a_i = EXP_W'(a); bus.b_i = EXP_W'(b);
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        // Inputs wander after the start cycle; the engine must hold its captured copy.
        bus.g_i = W'($urandom_range(0, 255)); bus.p_i = W'($urandom_range(0, 255));
        bus.a_i = EXP_W'($urandom_range(0, 255)); bus.b_i = EXP_W'($urandom_range(0, 255));

        k = 1; done_at = 0; busy_bad = 0;
        while (done_at == 0 && k <= 60) begin
            if (k == 1 && p != 0) begin
                check({tag, "_clr"}, {bus.pub_a_o, bus.pub_b_o, bus.key_a_o, bus.key_b_o}, 0);
                check({tag, "_err_start"}, 32'(bus.err_o), 0);
                check({tag, "_state_pa"}, 32'(bus.dbg_state), 32'(RUN_PA));
            end
            if (bus.done_o === 1'b1) begin
                done_at = k;
            end else begin
                if (bus.busy_o !== (p != 0)) busy_bad++;
                if (poke_start && k == 15) bus.start_i = 1'b1;
                if (poke_start && k == 16) bus.start_i = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        bus.start_i = 1'b0;

        xa = exp_q.pop_front(); xb = exp_q.pop_front();
        xka = exp_q.pop_front(); xkb = exp_q.pop_front();
        check({tag, "_latency"}, 32'(done_at), 32'(lat));
        check({tag, "_busy_run"}, 32'(busy_bad), 0);
        check({tag, "_busy_at_done"}, 32'(bus.busy_o), 0);
        check({tag, "_state_fin"}, 32'(bus.dbg_state), 32'(FIN));
        check({tag, "_err"}, 32'(bus.err_o), 32'(p == 0));
        check({tag, "_A"}, 32'(bus.pub_a_o), 32'(xa));
        check({tag, "_B"}, 32'(bus.pub_b_o), 32'(xb));
        check({tag, "_KA"}, 32'(bus.key_a_o), 32'(xka));
        check({tag, "_KB"}, 32'(bus.key_b_o), 32'(xkb));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done_o), 0);
        @(negedge clk);
        check({tag, "_hold"}, {bus.pub_a_o, bus.pub_b_o, bus.key_a_o, bus.key_b_o},
              {xa, xb, xka, xkb});
`ifdef DH_KEY_MATCH_EN
        check({tag, "_key_ok"}, 32'(bus.key_ok_o), 32'((xka == xkb) && (p != 0)));
`endif
    endtask

    task automatic reset_midrun();
        int dones;
        @(negedge clk);
        bus.g_i = 8'd5; bus.p_i = 8'd23; bus.a_i = 8'd6; bus.b_i = 8'd15;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        check("rst_no_done", 32'(dones), 0);
        check_all_zero("rst_after");
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.g_i = '0; bus.p_i = '0; bus.a_i = '0; bus.b_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
`ifdef DH_KEY_MATCH_EN
        check("reset_key_ok", 32'(bus.key_ok_o), 0);
`endif
        rst_n = 1'b1;

        run_check("plan_basic", 5, 23, 6, 15, 1'b1);
        run_check("plan_greduce", 28, 23, 6, 15, 1'b0);
        run_check("plan_p0", 5, 0, 6, 15, 1'b0);
        run_check("plan_after_p0", 5, 23, 6, 15, 1'b0);
        run_check("plan_a0", 5, 23, 0, 15, 1'b0);
        run_check("plan_b0", 7, 29, 11, 0, 1'b0);
        run_check("plan_p1", 5, 1, 6, 15, 1'b0);
        run_check("max_ops", 255, 255, 255, 255, 1'b0);
        run_check("p251", 254, 251, 255, 128, 1'b0);
        reset_midrun();
        run_check("post_reset", 5, 23, 6, 15, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int g, p, a, b;
            g = $urandom_range(0, 255);
            p = (i % 4 == 0) ? $urandom_range(0, 3) : $urandom_range(2, 255);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            run_check($sformatf("rand%0d", i), g, p, a, b, (i % 5 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dh_keyx_engine.md
Name: dh_keyx_engine

Overview:
- Parametrised Diffie-Hellman key-exchange engine, the successor to the fixed 4-bit lookup-table exponent path.
- Computes A = g^a mod p, B = g^b mod p, K_A = B^a mod p and K_B = A^b mod p with a sequential square-and-multiply core.
- Widths are generic; latency is fixed and independent of data.
- Sits between the keypad/register front end, which supplies g, p, a and b, and the display mux, which consumes the results.

Parameters:
- W, 8: width of g, p and all results.
- EXP_W, 8: width of the secret exponents a and b.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- g_i  in  W  generator/base.
- p_i  in  W  modulus.
- a_i  in  EXP_W  Alice's secret.
- b_i  in  EXP_W  Bob's secret.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse when all four results are valid.
- err_o  out  1  invalid modulus (p == 0); held until next accepted start.
- pub_a_o  out  W  A.
- pub_b_o  out  W  B.
- key_a_o  out  W  K_A.
- key_b_o  out  W  K_B.

Interface note: one clock; reset is asynchronous and active-low (CLK, RST_N).

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; operand registers 0.
- RST_N low mid-run aborts immediately. No done_o follows; results read 0.
- Inputs g, p, a, b are captured in the start cycle T. Later input changes are ignored until the next accepted start.
- start_i while busy is ignored.
- Top FSM states: IDLE -> RUN_PA -> RUN_PB -> RUN_KA -> RUN_KB -> FIN -> IDLE.
  - RUN_PA computes g^a, RUN_PB g^b, RUN_KA B^a, RUN_KB A^b.
  - Each RUN state issues a one-cycle core start on entry and leaves on core done.
  - Core start times: RUN_PA at T+1; each later run starts the cycle after the previous core done.
- Core run (start at cycle s):
  - Cycle s: load r = 1 mod p, x = base mod p, e = exponent.
  - Cycles s+1 .. s+EXP_W: one iteration each:
    - if e[0]: r <= (r*x) mod p;
    - x <= (x*x) mod p;
    - e <= e >> 1.
  - core done at s+EXP_W+1.
  - Iteration count is always EXP_W (constant time), including when e == 0.
- Arithmetic: products are 2W bits, reduced mod p back to W bits. No truncation before reduction.
- Timing: FIN asserts done_o at exactly T+4*EXP_W+9 (T+41 for EXP_W=8). busy_o is low in that same cycle.
- Result updates: each result register updates on its core's done. All four results hold until the next accepted start, which clears them to 0.
- p == 0: FSM goes IDLE -> FIN directly; err_o = 1; results 0; done_o at T+1.
- p == 1: normal run; every result is 0.
- g >= p: g is reduced at load; results equal those for g mod p.
- Exponent 0: corresponding result is 1 (for p > 1).

Optional Feature:
- Macro: DH_KEY_MATCH_EN.
- Defined:
  - adds output key_ok_o (1 bit, reset 0);
  - in FIN, key_ok_o <= (K_A == K_B) && !err_o;
  - key_ok_o is cleared on accepted start.
- Undefined: no port, no comparator; behaviour otherwise identical.

Decomposition:
- Package dh_pkg holds:
  - state enum (IDLE, RUN_PA, RUN_PB, RUN_KA, RUN_KB, FIN);
  - core-state enum (C_IDLE, C_LOAD, C_ITER, C_DONE);
  - localparam LAT = 4*EXP_W+9.
- One sub-module, dh_modexp_core (params W, EXP_W).
  - Ports: CLK, RST_N, start_i, base_i, exp_i, mod_i, done_o, result_o.
  - Instantiated once and time-shared across the four runs.

Test Plan:
- W=8, EXP_W=8: g=5, p=23, a=6, b=15, start -> A=8, B=19, K_A=K_B=2; done_o at T+41; busy high T+1..T+40.
- g=28, p=23, a=6, b=15 -> identical results to g=5 (base reduced).
- p=0 -> done_o at T+1, err_o=1, all results 0; next start with p=23 clears err_o.
- a=0, g=5, p=23, b=15 -> A=1, B=19, K_A=1, K_B=1.
- p=1 -> all results 0, err_o=0.
- RST_N low at T+20 of a run, high at T+22 -> all outputs 0, no done_o; start_i pulsed during busy -> ignored, done_o timing unchanged.
